alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_seq_fifo.sv | 53 +++++
 rtl/alu_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, idle opcode, instruction record and
// sequencer FSM state type for the ALU sequencer slice.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDA = 4'b0100;  // accumulate: ALU_Out + A
  localparam logic [3:0] OP_XOR  = 4'b0101;

  // Opcode the ALU sees whenever nothing is issuing; the ALU holds on it.
  localparam logic [3:0] ALU_IDLE_OP = 4'b1111;

  localparam int INSTR_W = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } instr_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: instruction queue for the ALU sequencer.
//   clk, reset      : clock, async active-high reset (pointers/count only)
//   push, wdata     : write one entry (caller guarantees !full)
//   pop, rdata      : rdata is the head entry, removed on pop (caller
//                     guarantees !empty)
//   full, empty     : occupancy flags decoded from the entry count
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: queues instructions and issues them one at a time to a
// registered ALU, captures each result and hands it to a consumer.
//   clk, reset                 : clock, async active-high reset
//   in_valid/in_ready          : instruction handshake (in_ready = !full)
//   in_opcode, in_A, in_B      : instruction fields
//   opcode, A, B               : drive the ALU; opcode = IDLE_OP unless issuing
//   ALU_Out                    : ALU registered result
//   res_valid/res_ready        : result handshake, res_data holds the result
//   busy                       : FSM not idle or queue non-empty
//   op_count                   : completed-instruction counter
// Build option: define ALU_SEQ_STATS_EN to build the op_count register;
// without it op_count is tied to zero.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] IDLE_OP    = ALU_IDLE_OP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [7:0]  in_A,
  input  logic [7:0]  in_B,
  output logic [3:0]  opcode,
  output logic [7:0]  A,
  output logic [7:0]  B,
  input  logic [7:0]  ALU_Out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        busy,
  output logic [15:0] op_count
);

  seq_state_e state, nxt;
  instr_t     wr_ins, head;
  logic       push, pop, full, empty;

  assign wr_ins = '{op: in_opcode, a: in_A, b: in_B};
  assign push   = in_valid && in_ready;

  alu_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_ins),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Pops happen only on the edge that enters ISSUE, so the head entry lands
  // in opcode/A/B together with the state change.
  always_comb begin
    nxt = state;
    pop = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          nxt = S_ISSUE;
          pop = 1'b1;
        end
      end
      S_ISSUE: nxt = S_WAIT;
      S_WAIT:  nxt = S_DONE;
      S_DONE: begin
        if (res_ready) begin
          if (!empty) begin
            nxt = S_ISSUE;
            pop = 1'b1;
          end else begin
            nxt = S_IDLE;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Opcode is live for the single ISSUE cycle only, so accumulate ops run
  // exactly once; A/B are left alone afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode   <= IDLE_OP;
      A        <= '0;
      B        <= '0;
      res_data <= '0;
    end else begin
      if (pop) begin
        opcode <= head.op;
        A      <= head.a;
        B      <= head.b;
      end else if (state == S_ISSUE) begin
        opcode <= IDLE_OP;
      end
      if (state == S_WAIT) res_data <= ALU_Out;
    end
  end

  assign res_valid = (state == S_DONE);
  assign in_ready  = !full;
  assign busy      = (state != S_IDLE) || !empty;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       op_cnt_q <= '0;
    else if (res_valid && res_ready) op_cnt_q <= op_cnt_q + 16'd1;
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = 16'h0000;
`endif

endmodule
